// File: rtl/riscv_crypto_ssm3_pkg.sv
// Shared SM3 constants, scheduler state encoding and a 32-bit rotate helper.
// Pure declarations; no clocked logic, no backpressure.
package riscv_crypto_ssm3_pkg;

    localparam int SM3_WORDS_IN  = 16;
    localparam int SM3_WORDS_EXP = 68;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } ssm3_state_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

endpackage

// File: rtl/riscv_crypto_ssm3_msg_sched_if.sv
// Word-stream handshake bundle: block loader -> scheduler -> round engine.
// Pure wiring; valid/ready on both sides.
interface riscv_crypto_ssm3_msg_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic [6:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_w, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_w, out_idx, out_last
    );
endinterface

// File: rtl/riscv_crypto_fu_ssm3.sv
// ssm3.p0 / ssm3.p1 permutation unit; result sign-extended to XLEN.
// Latency: combinational. Backpressure: none, result is valid whenever valid=1.
module riscv_crypto_fu_ssm3
    import riscv_crypto_ssm3_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [XLEN-1:0] rs1,
    input  logic            op_ssm3_p0,
    input  logic            op_ssm3_p1,
    output logic [XLEN-1:0] rd
);

    logic [31:0] x;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] r32;

    assign x   = rs1[31:0];
    assign p0  = x ^ rol32(x, 5'd9)  ^ rol32(x, 5'd17);
    assign p1  = x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
    assign r32 = !valid     ? 32'h0 :
                 op_ssm3_p0 ? p0    :
                 op_ssm3_p1 ? p1    : 32'h0;
    assign rd  = XLEN'($signed(r32));

endmodule

// File: rtl/riscv_crypto_ssm3_msg_sched.sv
// SM3 message expansion: loads 16 words, streams W[0..NWORDS-1] one per cycle.
// Latency: first word the cycle after the 16th accept; 16+NWORDS+1 cycles per block.
// Backpressure: out_ready=0 freezes window and outputs; in_ready only in LOAD.
module riscv_crypto_ssm3_msg_sched
    import riscv_crypto_ssm3_pkg::*;
#(
    parameter int NWORDS = SM3_WORDS_EXP
) (
    input  logic                              g_clk,
    input  logic                              g_resetn,
    input  logic                              flush,
    riscv_crypto_ssm3_msg_sched_if.slave      io,
    output logic                              busy
);

    localparam logic [6:0] LAST_IDX = 7'(NWORDS - 1);
    localparam logic [7:0] NW8      = 8'(NWORDS);
    localparam logic [4:0] LOAD_END = 5'(SM3_WORDS_IN - 1);

    ssm3_state_t state;
    logic [31:0] win [SM3_WORDS_IN];
    logic [4:0]  load_cnt;
    logic [6:0]  emit_idx;
    logic        in_rdy_q;
    logic        out_vld_q;
    logic        out_last_q;

    logic        in_fire;
    logic        out_fire;
    logic [31:0] p1_in;
    logic [31:0] p1_out;
    logic [31:0] w_next;
    logic [7:0]  next_j;

    assign in_fire  = io.in_valid & in_rdy_q;
    assign out_fire = out_vld_q & io.out_ready;
    assign p1_in    = win[0] ^ win[7] ^ rol32(win[13], 5'd15);
    assign next_j   = {1'b0, emit_idx} + 8'd16;

    riscv_crypto_fu_ssm3 #(.XLEN(32)) u_p1 (
        .valid      (1'b1),
        .rs1        (p1_in),
        .op_ssm3_p0 (1'b0),
        .op_ssm3_p1 (1'b1),
        .rd         (p1_out)
    );

    // Words beyond the emitted range are never needed, so keep the tail zero.
    assign w_next = (next_j >= NW8) ? 32'h0 : (p1_out ^ rol32(win[3], 5'd7) ^ win[10]);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= IDLE;
            load_cnt   <= '0;
            emit_idx   <= '0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            for (int k = 0; k < SM3_WORDS_IN; k++) win[k] <= '0;
        end else if (flush) begin
            state      <= IDLE;
            load_cnt   <= '0;
            emit_idx   <= '0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= LOAD;
                    in_rdy_q <= 1'b1;
                end
                LOAD: begin
                    if (in_fire) begin
                        for (int k = 0; k < SM3_WORDS_IN - 1; k++) win[k] <= win[k+1];
                        win[SM3_WORDS_IN-1] <= io.in_data;
                        load_cnt <= load_cnt + 5'd1;
                        if (load_cnt == LOAD_END) begin
                            state      <= EMIT;
                            in_rdy_q   <= 1'b0;
                            out_vld_q  <= 1'b1;
                            out_last_q <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        for (int k = 0; k < SM3_WORDS_IN - 1; k++) win[k] <= win[k+1];
                        win[SM3_WORDS_IN-1] <= w_next;
                        if (out_last_q) begin
                            state      <= IDLE;
                            out_vld_q  <= 1'b0;
                            out_last_q <= 1'b0;
                            emit_idx   <= '0;
                            load_cnt   <= '0;
                        end else begin
                            emit_idx   <= emit_idx + 7'd1;
                            out_last_q <= ((emit_idx + 7'd1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = in_rdy_q;
    assign io.out_valid = out_vld_q;
    assign io.out_w     = win[0];
    assign io.out_idx   = emit_idx;
    assign io.out_last  = out_last_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_riscv_crypto_ssm3_msg_sched.sv
// Bench for the SM3 message scheduler: NWORDS=68 and NWORDS=17 instances driven in lockstep,
// outputs collected per instance and compared against a reference expansion.
module tb_riscv_crypto_ssm3_msg_sched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] exp_t [68];
    typedef struct {
        logic [6:0]  idx;
        logic [31:0] w;
        logic        last;
    } obs_t;
    typedef struct {
        int          idx;
        logic [31:0] w;
    } vec_t;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        busy68;
    logic        busy17;

    riscv_crypto_ssm3_msg_sched_if if68 ();
    riscv_crypto_ssm3_msg_sched_if if17 ();

    assign if68.in_valid  = in_valid;
    assign if68.in_data   = in_data;
    assign if68.out_ready = out_ready;
    assign if17.in_valid  = in_valid;
    assign if17.in_data   = in_data;
    assign if17.out_ready = out_ready;

    riscv_crypto_ssm3_msg_sched #(.NWORDS(68)) u_dut68 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .io       (if68.slave),
        .busy     (busy68)
    );

    riscv_crypto_ssm3_msg_sched #(.NWORDS(17)) u_dut17 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .io       (if17.slave),
        .busy     (busy17)
    );

    always #5 g_clk = ~g_clk;

    int   checks = 0;
    int   failures = 0;
    obs_t q68[$];
    obs_t q17[$];

    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (if68.out_valid && out_ready) q68.push_back('{if68.out_idx, if68.out_w, if68.out_last});
            if (if17.out_valid && out_ready) q17.push_back('{if17.out_idx, if17.out_w, if17.out_last});
        end
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1f(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    function automatic exp_t expand(input blk_t m);
        exp_t w;
        for (int j = 0; j < 16; j++) w[j] = m[j];
        for (int j = 16; j < 68; j++)
            w[j] = p1f(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic load_words(input blk_t m, input int n);
        int t = 0;
        while (!(if68.in_ready && if17.in_ready) && t < 20) begin
            step();
            t++;
        end
        chk("load_ready", {if68.in_ready, if17.in_ready}, 2'b11);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = m[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic drain(input int stall_pct, output int cycles);
        int t = 0;
        bit d68 = 0;
        bit d17 = 0;
        bit l68;
        bit l17;
        while (!(d68 && d17) && t < 2000) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            l68 = if68.out_valid && if68.out_last && out_ready;
            l17 = if17.out_valid && if17.out_last && out_ready;
            step();
            t++;
            if (l68) begin
                chk("busy_drop68", {busy68, if68.out_valid}, 2'b00);
                d68 = 1;
            end
            if (l17) begin
                chk("busy_drop17", {busy17, if17.out_valid}, 2'b00);
                d17 = 1;
            end
        end
        out_ready = 1'b0;
        chk("drain_done", {d68, d17}, 2'b11);
        cycles = t;
    endtask

    task automatic cmp_stream(input int sel, input blk_t m, input string tag);
        exp_t w;
        obs_t o;
        int   n;
        int   sz;
        w  = expand(m);
        n  = (sel != 0) ? 17 : 68;
        sz = (sel != 0) ? q17.size() : q68.size();
        chk({tag, "_count"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            if (sel != 0) o = q17[i];
            else          o = q68[i];
            chk($sformatf("%s_w%0d", tag, i), {o.idx, o.w, o.last}, {7'(i), w[i], (i == n - 1)});
        end
    endtask

    task automatic clear_q();
        q68.delete();
        q17.delete();
    endtask

    initial begin
        blk_t abc;
        blk_t zero;
        blk_t rnd;
        vec_t tbl [8];
        int   cyc;
        int   t;

        abc = '{default: 32'h0};
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        zero = '{default: 32'h0};
        tbl = '{'{0, 32'h61626380}, '{1, 32'h0}, '{15, 32'h00000018}, '{16, 32'h9092e200},
                '{17, 32'h0}, '{18, 32'h000c0606}, '{19, 32'h719c70ed}, '{21, 32'h8001801f}};

        // Reset state
        #12;
        chk("rst68", {if68.in_ready, if68.out_valid, if68.out_w, if68.out_idx, if68.out_last, busy68}, 64'h0);
        chk("rst17", {if17.in_ready, if17.out_valid, if17.out_w, if17.out_idx, if17.out_last, busy17}, 64'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        // "abc" block, no stalls
        clear_q();
        load_words(abc, 16);
        chk("first_valid", {if68.out_valid, if68.in_ready, if68.out_idx, busy68}, {1'b1, 1'b0, 7'd0, 1'b1});
        drain(0, cyc);
        chk("abc_cycles", cyc, 68);
        for (int i = 0; i < 8; i++)
            chk($sformatf("abc_tbl%0d", tbl[i].idx), q68[tbl[i].idx].w, tbl[i].w);
        cmp_stream(0, abc, "abc68");
        cmp_stream(1, abc, "abc17");

        // All-zero block
        clear_q();
        load_words(zero, 16);
        drain(0, cyc);
        cmp_stream(0, zero, "zero68");
        cmp_stream(1, zero, "zero17");

        // 50% downstream stalls
        clear_q();
        load_words(abc, 16);
        drain(50, cyc);
        cmp_stream(0, abc, "stall68");
        cmp_stream(1, abc, "stall17");

        // Flush part-way through LOAD
        clear_q();
        load_words(abc, 7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_load", {if68.in_ready, busy68, if17.in_ready, busy17}, 4'b0000);
        load_words(abc, 16);
        drain(0, cyc);
        cmp_stream(0, abc, "fload68");
        cmp_stream(1, abc, "fload17");

        // Flush in EMIT at idx 30
        clear_q();
        load_words(abc, 16);
        out_ready = 1'b1;
        t = 0;
        while (if68.out_idx != 7'd30 && t < 100) begin
            step();
            t++;
        end
        chk("reach_idx30", {if68.out_valid, if68.out_idx}, {1'b1, 7'd30});
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_emit", {if68.out_valid, busy68, if68.out_idx}, 9'h0);
        repeat (20) step();
        out_ready = 1'b0;
        chk("no_words_after_flush", q68.size(), 31);
        cmp_stream(1, abc, "femit17");
        clear_q();
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_words(rnd, 16);
        drain(0, cyc);
        cmp_stream(0, rnd, "postflush68");
        cmp_stream(1, rnd, "postflush17");

        // Random blocks with random stall rates
        for (int b = 0; b < 3; b++) begin
            clear_q();
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            load_words(rnd, 16);
            drain($urandom_range(0, 70), cyc);
            cmp_stream(0, rnd, $sformatf("rnd%0d_68", b));
            cmp_stream(1, rnd, $sformatf("rnd%0d_17", b));
        end

        // Asynchronous reset mid-EMIT
        clear_q();
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_words(rnd, 16);
        out_ready = 1'b1;
        t = 0;
        while (if68.out_idx != 7'd40 && t < 100) begin
            step();
            t++;
        end
        #3;
        g_resetn = 1'b0;
        #1;
        chk("arst68", {if68.in_ready, if68.out_valid, if68.out_w, if68.out_idx, if68.out_last, busy68}, 64'h0);
        chk("arst17", {if17.in_ready, if17.out_valid, if17.out_w, if17.out_idx, if17.out_last, busy17}, 64'h0);
        out_ready = 1'b0;
        @(posedge g_clk);
        #4;
        g_resetn = 1'b1;
        t = 0;
        while (!(if68.in_ready && if17.in_ready) && t < 5) begin
            step();
            t++;
        end
        chk("rst_ready_lat", (t <= 2), 1'b1);
        clear_q();
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_words(rnd, 16);
        drain(50, cyc);
        cmp_stream(0, rnd, "postrst68");
        cmp_stream(1, rnd, "postrst17");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
